tm_tape_ctrl: RTL

- Tape-and-head sequencer for the single-tape bracket-matching Turing machine core.
- Owns a DEPTH-cell 8-bit tape RAM, host load/clear/readback and the head pointer.
- Drives the core's datain, writes back its dataout, steps the head by its move, and reports halt/result, step count, timeout and head-range fault.
- Sits between the host/bench and the unmodified core; that core has no enable, so this block gates its steps with an idle symbol.

---
 rtl/tm_tape_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/tm_tape_ctrl.sv
// Tape-and-head sequencer for the bracket-matching Turing machine core.
// Owns the tape RAM and head, feeds the core one symbol per step and commits its write/move.
module tm_tape_ctrl #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter int          SW        = 8,
  parameter int          MAX_STEPS = 255,
  parameter logic [7:0]  IDLE_SYM  = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          fault,
  output logic [7:0]    result,
  output logic [SW-1:0] steps,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          tm_reset,
  output logic [7:0]    tm_datain,
  input  logic [7:0]    tm_dataout,
  input  logic          tm_move,
  input  logic          tm_halt
);

  // Host load handshake: a beat transfers on a clock edge where load_valid and
  // load_ready are both 1; load_ready never depends on load_valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [AW-1:0] head;
  logic [AW-1:0] clr_addr;
  logic [AW:0]   ptr;
  logic          armed;
  logic [7:0]    tape [0:(1<<AW)-1];

  logic          host_st;
  logic          can_load;
  logic          load_fire;
  logic          at_edge;
  logic          hit_max;
  logic          last_clr;
  logic [SW-1:0] steps_inc;
  logic [AW-1:0] head_mv;
  logic          tape_we;
  logic [AW-1:0] tape_wa;
  logic [7:0]    tape_wd;

  assign host_st   = (state == S_IDLE) || (state == S_DONE);
  // armed keeps load_ready low while reset is held and for the first edge after it
  assign can_load  = host_st && armed && (ptr < (AW+1)'(DEPTH));
  assign load_ready = can_load;
  assign load_fire = load_valid && can_load && !clear && !start;

  assign busy      = (state == S_CLEAR) || (state == S_FEED) || (state == S_WB);
  assign done      = (state == S_DONE);
  assign tm_reset  = !((state == S_FEED) || (state == S_WB));
  assign tm_datain = (state == S_FEED) ? tape[head] : IDLE_SYM;

  assign steps_inc = steps + SW'(1);
  assign hit_max   = (steps_inc == SW'(MAX_STEPS));
  assign at_edge   = tm_move ? (head == '0) : (head == AW'(DEPTH-1));
  assign head_mv   = tm_move ? (head - AW'(1)) : (head + AW'(1));
  assign last_clr  = (clr_addr == AW'(DEPTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (clear)      state_n = S_CLEAR;
        else if (start) state_n = S_FEED;
      end
      S_CLEAR: if (last_clr) state_n = S_IDLE;
      S_FEED:  state_n = S_WB;
      // a halting core reports halt on the pair after its last write, which commits nothing
      S_WB:    state_n = (tm_halt || at_edge || hit_max) ? S_DONE : S_FEED;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tape_we = 1'b0;
    tape_wa = head;
    tape_wd = tm_dataout;
    case (state)
      S_CLEAR: begin
        tape_we = 1'b1;
        tape_wa = clr_addr;
        tape_wd = 8'h00;
      end
      S_WB: tape_we = !tm_halt;
      default: begin
        if (load_fire) begin
          tape_we = 1'b1;
          tape_wa = ptr[AW-1:0];
          tape_wd = load_data;
        end
      end
    endcase
  end

  // Tape contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (tape_we) tape[tape_wa] <= tape_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= tape[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      ptr      <= '0;
      clr_addr <= '0;
      armed    <= 1'b0;
      timeout  <= 1'b0;
      fault    <= 1'b0;
      result   <= 8'h00;
      steps    <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (clear) begin
            clr_addr <= '0;
            timeout  <= 1'b0;
            fault    <= 1'b0;
          end else if (start) begin
            head    <= '0;
            steps   <= '0;
            result  <= 8'h00;
            ptr     <= '0;
            timeout <= 1'b0;
            fault   <= 1'b0;
          end else if (load_fire) begin
            ptr <= ptr + (AW+1)'(1);
          end
        end
        S_CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (last_clr) ptr <= '0;
        end
        S_WB: begin
          if (!tm_halt) begin
            result <= tm_dataout;
            steps  <= steps_inc;
            // a step that would walk off the tape still commits its write but not its move
            if (at_edge) begin
              fault <= 1'b1;
            end else begin
              head <= head_mv;
              if (hit_max) timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
